// File: rtl/alu4_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU
// among four requesters; one grant, hold, capture, ack.
module alu4_req_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [3:0]  ack,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [3:0]  alu_y,
  input  logic        alu_co,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [3:0]  rsp_y,
  output logic        rsp_co,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] cur_id;
  logic [3:0] cnt;
  logic [1:0] win_id;
  logic       win_vld;
  logic [2:0] op_arr [4];
  logic [3:0] a_arr  [4];
  logic [3:0] b_arr  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      op_arr[i] = req_op[3*i +: 3];
      a_arr[i]  = req_a[4*i +: 4];
      b_arr[i]  = req_b[4*i +: 4];
    end
  end

  // Search starts just past the last grant; ptr itself comes last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!win_vld && req[ptr + 2'(i)]) begin
        win_vld = 1'b1;
        win_id  = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      cur_id    <= 2'd0;
      cnt       <= 4'd0;
      ack       <= 4'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_y     <= 4'd0;
      rsp_co    <= 1'b0;
    end else begin
      ack       <= 4'd0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            alu_op <= op_arr[win_id];
            alu_a  <= a_arr[win_id];
            alu_b  <= b_arr[win_id];
            cur_id <= win_id;
            cnt    <= 4'(HOLD_CYCLES);
            state  <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_y     <= alu_y;
            rsp_co    <= alu_co;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            ack       <= 4'd1 << cur_id;
            state     <= DONE;
          end
        end
        DONE: begin
          ptr   <= cur_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu4_req_arbiter.sv
// Scoreboard bench for alu4_req_arbiter: two instances
// (HOLD 1 and 3) against a transaction-level model.
module tb_alu4_req_arbiter;

  typedef struct {
    int k;
    int id;
    int op;
    int a;
    int b;
    int due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst       [2];
  logic [3:0]  req       [2];
  logic [11:0] req_op    [2];
  logic [15:0] req_a     [2];
  logic [15:0] req_b     [2];
  logic [3:0]  ack       [2];
  logic [3:0]  alu_a     [2];
  logic [3:0]  alu_b     [2];
  logic [2:0]  alu_op    [2];
  logic [3:0]  alu_y     [2];
  logic        alu_co    [2];
  logic        rsp_valid [2];
  logic [1:0]  rsp_id    [2];
  logic [3:0]  rsp_y     [2];
  logic        rsp_co    [2];
  logic        busy      [2];

  exp_t       q[$];
  exp_t       cur     [2];
  int         mptr    [2];
  int         gfrom   [2];
  int         free_at [2];
  int         done_at [2];
  int         sid     [2];
  bit         serving [2];
  bit         mon_en  [2];
  logic [3:0] jd      [2];

  alu4_req_arbiter #(.HOLD_CYCLES(1)) u0 (
    .clk(clk), .reset(rst[0]), .req(req[0]),
    .req_op(req_op[0]), .req_a(req_a[0]),
    .req_b(req_b[0]), .ack(ack[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_op(alu_op[0]), .alu_y(alu_y[0]),
    .alu_co(alu_co[0]), .rsp_valid(rsp_valid[0]),
    .rsp_id(rsp_id[0]), .rsp_y(rsp_y[0]),
    .rsp_co(rsp_co[0]), .busy(busy[0])
  );

  alu4_req_arbiter #(.HOLD_CYCLES(3)) u1 (
    .clk(clk), .reset(rst[1]), .req(req[1]),
    .req_op(req_op[1]), .req_a(req_a[1]),
    .req_b(req_b[1]), .ack(ack[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_op(alu_op[1]), .alu_y(alu_y[1]),
    .alu_co(alu_co[1]), .rsp_valid(rsp_valid[1]),
    .rsp_id(rsp_id[1]), .rsp_y(rsp_y[1]),
    .rsp_co(rsp_co[1]), .busy(busy[1])
  );

  assign {alu_co[0], alu_y[0]} =
    {1'b0, alu_a[0]} + {1'b0, alu_b[0]};
  assign {alu_co[1], alu_y[1]} =
    {1'b0, alu_a[1]} + {1'b0, alu_b[1]};

  function automatic int hold(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input int k, input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL u%0d %s: got %0h want %0h",
               k, nm, got, want);
    end
  endtask

  task automatic flush(input int k);
    for (int j = q.size() - 1; j >= 0; j--)
      if (q[j].k == k) q.delete(j);
    mptr[k]    = 3;
    gfrom[k]   = -100;
    free_at[k] = 0;
    serving[k] = 1'b0;
  endtask

  // One decision per free slot: nearest pending requester
  // after the last one served, wrapping around.
  task automatic decide(input int k);
    int best;
    int bd;
    int d;
    int n;
    exp_t e;
    n = cyc + 1;
    if (rst[k] || n < free_at[k] || req[k] == 4'd0) return;
    best = -1;
    bd   = 4;
    for (int i = 0; i < 4; i++) begin
      d = (i - mptr[k] + 7) % 4;
      if (req[k][i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    e.k   = k;
    e.id  = best;
    e.op  = int'(req_op[k][3*best +: 3]);
    e.a   = int'(req_a[k][4*best +: 4]);
    e.b   = int'(req_b[k][4*best +: 4]);
    e.due = n + hold(k);
    q.push_back(e);
    cur[k]     = e;
    mptr[k]    = best;
    gfrom[k]   = n;
    free_at[k] = n + hold(k) + 2;
    done_at[k] = n + hold(k);
    sid[k]     = best;
    serving[k] = 1'b1;
  endtask

  task automatic step(input int k);
    decide(k);
    @(negedge clk);
    #1;
    jd[k] = 4'd0;
    if (serving[k] && cyc == done_at[k]) begin
      req[k][sid[k]] = 1'b0;
      jd[k][sid[k]]  = 1'b1;
      serving[k]     = 1'b0;
    end
  endtask

  task automatic raise(input int k, input int i);
    req_op[k][3*i +: 3] = 3'($urandom);
    req_a[k][4*i +: 4]  = 4'($urandom);
    req_b[k][4*i +: 4]  = 4'($urandom);
    req[k][i]           = 1'b1;
  endtask

  task automatic zero_chk(input int k, input string nm);
    chk(k, nm, 32'({ack[k], alu_a[k], alu_b[k],
                    alu_op[k], rsp_valid[k], rsp_id[k],
                    rsp_y[k], rsp_co[k], busy[k]}), 32'd0);
  endtask

  task automatic mon(input int k);
    int   j;
    int   w;
    exp_t e;
    if (rsp_valid[k]) begin
      j = -1;
      for (int i = 0; i < q.size(); i++)
        if (j < 0 && q[i].k == k) j = i;
      if (j < 0) begin
        chk(k, "rsp_spurious", 32'(rsp_valid[k]), 32'd0);
      end else begin
        e = q[j];
        q.delete(j);
        chk(k, "rsp_id", 32'(rsp_id[k]), e.id);
        chk(k, "rsp_y", 32'(rsp_y[k]), (e.a + e.b) % 16);
        chk(k, "rsp_co", 32'(rsp_co[k]),
            32'((e.a + e.b) > 15));
        chk(k, "ack", 32'(ack[k]), 1 << e.id);
        chk(k, "rsp_cycle", cyc, e.due);
      end
    end else begin
      chk(k, "ack_idle", 32'(ack[k]), 32'd0);
    end
    w = int'(cyc >= gfrom[k] && cyc <= gfrom[k] + hold(k));
    chk(k, "busy", 32'(busy[k]), w);
    if (w != 0) begin
      chk(k, "alu_op", 32'(alu_op[k]), cur[k].op);
      chk(k, "alu_a", 32'(alu_a[k]), cur[k].a);
      chk(k, "alu_b", 32'(alu_b[k]), cur[k].b);
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (mon_en[k]) mon(k);

  task automatic run(input int k);
    int h;
    logic [3:0] m;
    h = hold(k);
    rst[k]    = 1'b1;
    req[k]    = 4'd0;
    req_op[k] = 12'd0;
    req_a[k]  = 16'd0;
    req_b[k]  = 16'd0;
    jd[k]     = 4'd0;
    flush(k);
    step(k);
    step(k);
    zero_chk(k, "reset_state");
    mon_en[k] = 1'b1;
    rst[k]    = 1'b0;
    // single request 9+8
    req_op[k][2:0] = 3'b101;
    req_a[k][3:0]  = 4'h9;
    req_b[k][3:0]  = 4'h8;
    req[k]         = 4'b0001;
    repeat (h + 4) step(k);
    // operands scrambled after grant
    req_op[k][8:6]  = 3'($urandom);
    req_a[k][11:8]  = 4'h3;
    req_b[k][11:8]  = 4'h4;
    req[k]          = 4'b0100;
    step(k);
    step(k);
    req_a[k][11:8]  = 4'hf;
    req_b[k][11:8]  = 4'hf;
    req_op[k][8:6]  = ~req_op[k][8:6];
    repeat (h + 3) step(k);
    // all four requesting continuously
    for (int i = 0; i < 4; i++) raise(k, i);
    repeat (5 * (h + 2) + 2) begin
      m = jd[k];
      step(k);
      for (int i = 0; i < 4; i++)
        if (m[i]) raise(k, i);
    end
    // random traffic
    repeat (400) begin
      for (int i = 0; i < 4; i++)
        if (!req[k][i] && !jd[k][i] &&
            !(serving[k] && sid[k] == i) &&
            $urandom_range(3) == 0)
          raise(k, i);
      if (serving[k] && cyc < done_at[k]) begin
        if ($urandom_range(1) == 1) begin
          req_a[k][4*sid[k] +: 4]  = 4'($urandom);
          req_b[k][4*sid[k] +: 4]  = 4'($urandom);
          req_op[k][3*sid[k] +: 3] = 3'($urandom);
        end
        if ($urandom_range(15) == 0)
          req[k][sid[k]] = 1'b0;
      end
      step(k);
    end
    repeat (4 * (h + 2) + 2) step(k);
    // reset in the middle of an operation
    raise(k, 2);
    repeat (h + 3) step(k);
    raise(k, 2);
    step(k);
    if (h > 1) step(k);
    rst[k] = 1'b1;
    req[k] = 4'd0;
    flush(k);
    step(k);
    zero_chk(k, "reset_mid");
    rst[k] = 1'b0;
    raise(k, 1);
    raise(k, 3);
    repeat (2 * (h + 2) + 2) step(k);
    // requester 3 withdraws during EXEC
    raise(k, 3);
    step(k);
    req[k][3] = 1'b0;
    repeat (h + 6) step(k);
  endtask

  initial begin
    int left;
    fork
      run(0);
      run(1);
    join
    for (int k = 0; k < 2; k++) begin
      left = 0;
      foreach (q[i]) if (q[i].k == k) left++;
      chk(k, "rsp_missing", left, 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

endmodule
